// File: rtl/alu_pkg.sv
// Shared opcode encodings, FSM states and flag bit positions for the
// handshaked sequential ALU.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SLT  = 4'b0101;
    localparam logic [3:0] OP_SLTU = 4'b0110;
    localparam logic [3:0] OP_SLL  = 4'b0111;
    localparam logic [3:0] OP_SRL  = 4'b1000;
    localparam logic [3:0] OP_SRA  = 4'b1001;
    localparam logic [3:0] OP_MUL  = 4'b1010;
    localparam logic [3:0] OP_DIVU = 4'b1011;
    localparam logic [3:0] OP_REMU = 4'b1100;

    localparam int F_N = 3;
    localparam int F_Z = 2;
    localparam int F_C = 1;
    localparam int F_V = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic is_iter_op(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/alu_iter_muldiv.sv
// Iterative engine: shift-add multiply (low half) and restoring unsigned
// divide/remainder, one iteration per clock, WIDTH iterations per operation.
module alu_iter_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CNT_W = $clog2(WIDTH);

    logic             running;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       op_q;

    logic [WIDTH-1:0] acc, mcand, mplier;
    logic [WIDTH-1:0] rem, quo, divisor;

    logic [WIDTH-1:0] acc_n, mcand_n, mplier_n;
    logic [WIDTH-1:0] rem_n, quo_n, diff;
    logic [WIDTH:0]   rem_sh;

    always_comb begin
        acc_n    = mplier[0] ? acc + mcand : acc;
        mcand_n  = mcand << 1;
        mplier_n = mplier >> 1;

        // Restoring step: shift in the next dividend bit, subtract if it fits.
        rem_sh = {rem, quo[WIDTH-1]};
        diff   = rem_sh[WIDTH-1:0] - divisor;
        if (rem_sh >= {1'b0, divisor}) begin
            rem_n = diff;
            quo_n = {quo[WIDTH-2:0], 1'b1};
        end else begin
            rem_n = rem_sh[WIDTH-1:0];
            quo_n = {quo[WIDTH-2:0], 1'b0};
        end
    end

    // The final iteration's value is presented alongside done so the top
    // can register it on the same edge the last iteration completes.
    assign done = running && (cnt == CNT_W'(WIDTH - 1));

    always_comb begin
        result = acc_n;
        if (op_q == OP_DIVU) result = quo_n;
        else if (op_q == OP_REMU) result = rem_n;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            running <= 1'b0;
            cnt     <= '0;
            op_q    <= OP_MUL;
        end else if (start) begin
            running <= 1'b1;
            cnt     <= '0;
            op_q    <= op;
        end else if (running) begin
            cnt <= cnt + 1'b1;
            if (done) running <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (start) begin
            acc     <= '0;
            mcand   <= A;
            mplier  <= B;
            rem     <= '0;
            quo     <= A;
            divisor <= B;
        end else if (running) begin
            acc    <= acc_n;
            mcand  <= mcand_n;
            mplier <= mplier_n;
            rem    <= rem_n;
            quo    <= quo_n;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Handshaked sequential ALU: single-cycle fast path for arithmetic/logic/
// compare/shift, iterative engine for MUL/DIVU/REMU, NZCV flags.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int MUL_EN = 1,
    parameter int DIV_EN = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       ALUControl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Result,
    output logic [3:0]       flags,
    output logic             illegal
);

    localparam int SH_W = $clog2(WIDTH);

    state_t           state, state_n;
    logic             op_ill, go_iter, accept, start;
    logic             md_done;
    logic [WIDTH-1:0] md_result;
    logic [WIDTH+3:0] fast;

    function automatic logic [WIDTH+3:0] fast_op(input logic [3:0] op,
                                                 input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b,
                                                 input logic ill);
        logic signed [WIDTH-1:0] sa, sb;
        logic [WIDTH:0]          sum;
        logic [WIDTH-1:0]        r;
        logic [3:0]              f;
        sa  = a;
        sb  = b;
        sum = '0;
        r   = '0;
        f   = '0;
        case (op)
            OP_ADD: begin
                sum    = {1'b0, a} + {1'b0, b};
                r      = sum[WIDTH-1:0];
                f[F_C] = sum[WIDTH];
                f[F_V] = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                sum    = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
                r      = sum[WIDTH-1:0];
                f[F_C] = sum[WIDTH];
                f[F_V] = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_SLT:  r = {{(WIDTH-1){1'b0}}, (sa < sb)};
            OP_SLTU: r = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_SLL:  r = a << b[SH_W-1:0];
            OP_SRL:  r = a >> b[SH_W-1:0];
            OP_SRA:  r = $unsigned(sa >>> b[SH_W-1:0]);
            default: r = '0;
        endcase
        if (ill) begin
            r = '0;
            f = '0;
        end
        f[F_N] = r[WIDTH-1];
        f[F_Z] = (r == '0);
        return {f, r};
    endfunction

    always_comb begin
        op_ill = (ALUControl > OP_REMU)
               || ((ALUControl == OP_MUL) && (MUL_EN == 0))
               || (((ALUControl == OP_DIVU) || (ALUControl == OP_REMU)) && (DIV_EN == 0));
        go_iter = is_iter_op(ALUControl) && !op_ill;
        fast    = fast_op(ALUControl, A, B, op_ill);
    end

    always_comb begin
        state_n   = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;
        start     = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = !rst;
                if (in_valid) begin
                    accept  = 1'b1;
                    start   = go_iter;
                    state_n = go_iter ? ST_BUSY : ST_DONE;
                end
            end
            ST_BUSY: begin
                if (md_done) state_n = ST_DONE;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_n;
    end

    // Output register: fast result at accept, iterative result on its last step.
    always_ff @(posedge clk) begin
        if (rst) begin
            Result  <= '0;
            flags   <= '0;
            illegal <= 1'b0;
        end else if (accept && !go_iter) begin
            flags   <= fast[WIDTH+3:WIDTH];
            Result  <= fast[WIDTH-1:0];
            illegal <= op_ill;
        end else if ((state == ST_BUSY) && md_done) begin
            Result  <= md_result;
            flags   <= {md_result[WIDTH-1], (md_result == '0), 2'b00};
            illegal <= 1'b0;
        end
    end

    generate
        if ((MUL_EN != 0) || (DIV_EN != 0)) begin : g_iter
            alu_iter_muldiv #(.WIDTH(WIDTH)) u_iter (
                .clk    (clk),
                .rst    (rst),
                .start  (start),
                .op     (ALUControl),
                .A      (A),
                .B      (B),
                .done   (md_done),
                .result (md_result)
            );
        end else begin : g_no_iter
            assign md_done   = 1'b0;
            assign md_result = '0;
        end
    endgenerate

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: directed ops push expectations, a monitor
// pops and compares at each output handshake.
module tb_alu_seq;
    import alu_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] A, B;
    logic [3:0]   ALUControl;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] Result;
    logic [3:0]   flags;
    logic         illegal;

    typedef struct {
        logic [W-1:0] r;
        logic [3:0]   f;
        logic         il;
        int           lat;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   last_accept = 0;
    bit   seen_valid = 0;

    alu_seq #(.WIDTH(W), .MUL_EN(1), .DIV_EN(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .A          (A),
        .B          (B),
        .ALUControl (ALUControl),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .Result     (Result),
        .flags      (flags),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: latency on first sight of out_valid, contents at handshake.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            seen_valid = 0;
        end else if (out_valid) begin
            if (!seen_valid) begin
                seen_valid = 1;
                if (q.size() > 0) check("latency", 64'(cyc - last_accept + 1), 64'(q[0].lat));
            end
            if (out_ready) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_output: got Result=%0h with nothing expected", Result);
                end else begin
                    e = q.pop_front();
                    check("result", 64'(Result), 64'(e.r));
                    check("flags", 64'(flags), 64'(e.f));
                    check("illegal", 64'(illegal), 64'(e.il));
                end
                seen_valid = 0;
            end
        end
    end

    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] er, input logic [3:0] ef, input logic eil,
                         input int lat, input bit push);
        exp_t e;
        int   n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, n);
            return;
        end
        A = a;
        B = b;
        ALUControl = op;
        in_valid = 1'b1;
        if (push) begin
            e.r = er; e.f = ef; e.il = eil; e.lat = lat;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        last_accept = cyc;
        in_valid = 1'b0;
        A = $urandom;
        B = $urandom;
        ALUControl = OP_SUB;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((q.size() != 0 || out_valid) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0 || out_valid) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: %0d results outstanding, required 0", q.size());
        end
    endtask

    initial begin
        int vcount;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        A = '0;
        B = '0;
        ALUControl = OP_ADD;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_result", 64'(Result), 64'd0);
        check("rst_flags", 64'(flags), 64'd0);
        check("rst_illegal", 64'(illegal), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", 64'(in_ready), 64'd1);

        // Fast path
        issue(OP_ADD,  32'hFFFF_FFFF, 32'h1,  32'h0,         4'b0110, 1'b0, 1, 1);
        issue(OP_SUB,  32'h8000_0000, 32'h1,  32'h7FFF_FFFF, 4'b0011, 1'b0, 1, 1);
        issue(OP_OR,   32'h0000_F0F0, 32'h0F0F, 32'h0000_FFFF, 4'b0000, 1'b0, 1, 1);
        issue(OP_XOR,  32'hAAAA_5555, 32'hAAAA_5555, 32'h0, 4'b0100, 1'b0, 1, 1);
        // Shifts and compares (only B[4:0] matters for shifts)
        issue(OP_SRA,  32'h8000_0000, 32'h24, 32'hF800_0000, 4'b1000, 1'b0, 1, 1);
        issue(OP_SRL,  32'h8000_0000, 32'h24, 32'h0800_0000, 4'b0000, 1'b0, 1, 1);
        issue(OP_SLL,  32'h8000_0000, 32'h24, 32'h0,         4'b0100, 1'b0, 1, 1);
        issue(OP_SLT,  32'hFFFF_FFFF, 32'h1,  32'h1,         4'b0000, 1'b0, 1, 1);
        issue(OP_SLTU, 32'hFFFF_FFFF, 32'h1,  32'h0,         4'b0100, 1'b0, 1, 1);

        // Multiply with in_valid pulses during BUSY
        issue(OP_MUL, 32'd12345, 32'd6789, 32'd83810205, 4'b0000, 1'b0, 33, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            ALUControl = OP_ADD;
            A = 32'd1;
            B = 32'd1;
            check("busy_in_ready", 64'(in_ready), 64'd0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        wait_drain();

        // Divide, including divide by zero
        issue(OP_DIVU, 32'd100, 32'd7, 32'd14,         4'b0000, 1'b0, 33, 1);
        issue(OP_REMU, 32'd100, 32'd7, 32'd2,          4'b0000, 1'b0, 33, 1);
        issue(OP_DIVU, 32'd5,   32'd0, 32'hFFFF_FFFF,  4'b1000, 1'b0, 33, 1);
        issue(OP_REMU, 32'd5,   32'd0, 32'd5,          4'b0000, 1'b0, 33, 1);
        wait_drain();

        // Backpressure: hold the result in DONE for 10 cycles
        out_ready = 1'b0;
        issue(OP_SUB, 32'd5, 32'd5, 32'h0, 4'b0110, 1'b0, 1, 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_out_valid", 64'(out_valid), 64'd1);
            check("bp_in_ready", 64'(in_ready), 64'd0);
            check("bp_result", 64'(Result), 64'd0);
            check("bp_flags", 64'(flags), 64'b0110);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("release_in_ready", 64'(in_ready), 64'd1);
        issue(4'b1111, 32'h1234, 32'h5678, 32'h0, 4'b0100, 1'b1, 1, 1);
        wait_drain();

        // Reset in the middle of a multiply
        issue(OP_MUL, 32'd12345, 32'd6789, 32'd0, 4'b0000, 1'b0, 33, 0);
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("abort_in_ready", 64'(in_ready), 64'd1);
        vcount = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) vcount++;
        end
        check("abort_no_valid", 64'(vcount), 64'd0);
        issue(OP_ADD, 32'd2, 32'd3, 32'd5, 4'b0000, 1'b0, 1, 1);
        wait_drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
